// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester and dmem pin bundle for the data memory arbiter
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data, mem_wren
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester single-port data memory arbiter and access sequencer
module dmem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clock,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              owner;
    logic              own_we;
    logic              last;
    logic [CNT_W-1:0]  cnt;

    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // On a tie the round-robin pointer hands the slot to the port not served last.
    always_comb begin
        win = 1'b0;
        if (bus.req1 && !bus.req0) begin
            win = 1'b1;
        end else if (bus.req0 && bus.req1 && FIXED_PRIO == 0) begin
            win = !last;
        end
        sel_we   = win ? bus.we1    : bus.we0;
        sel_addr = win ? bus.addr1  : bus.addr0;
        sel_data = win ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            owner           <= 1'b0;
            own_we          <= 1'b0;
            last            <= 1'b1;
            cnt             <= '0;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.rvalid0     <= 1'b0;
            bus.rvalid1     <= 1'b0;
            bus.rdata0      <= '0;
            bus.rdata1      <= '0;
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            bus.mem_wren    <= 1'b0;
        end else begin
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.rvalid0  <= 1'b0;
            bus.rvalid1  <= 1'b0;
            bus.mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner           <= win;
                        last            <= win;
                        own_we          <= sel_we;
                        bus.mem_address <= sel_addr;
                        bus.mem_data    <= sel_data;
                        bus.mem_wren    <= sel_we;
                        bus.gnt0        <= !win;
                        bus.gnt1        <= win;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_we) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_q is valid during the final WAIT cycle; capture it and pulse rvalid next.
                    if (cnt == CNT_W'(1)) begin
                        if (owner) begin
                            bus.rdata1  <= bus.mem_q;
                            bus.rvalid1 <= 1'b1;
                        end else begin
                            bus.rdata0  <= bus.mem_q;
                            bus.rvalid0 <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter (three configurations)
module tb_dmem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        rq [3][2];
    logic        wq [3][2];
    logic [11:0] aq [3][2];
    logic [31:0] dq [3][2];

    wire  [2:0]  o_gnt0, o_gnt1, o_rv0, o_rv1, o_wren;
    wire  [11:0] o_addr [3];
    wire  [31:0] o_data [3];
    wire  [31:0] o_rd0  [3];
    wire  [31:0] o_rd1  [3];

    function automatic logic [31:0] init_word(input int k, input int a);
        return 32'h5000_0000 + 32'(k) * 32'h0100_0000 + 32'(a);
    endfunction

    // Instance 0: round-robin RD_LAT=1, instance 1: fixed priority RD_LAT=1, instance 2: round-robin RD_LAT=3.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 2) ? 3 : 1;
        dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
        logic [31:0] mem  [4096];
        logic [31:0] pipe [L];

        dmem_port_arbiter #(
            .ADDR_W(12), .DATA_W(32), .RD_LAT(L), .FIXED_PRIO((k == 1) ? 1 : 0)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus)
        );

        assign bus.req0   = rq[k][0];
        assign bus.req1   = rq[k][1];
        assign bus.we0    = wq[k][0];
        assign bus.we1    = wq[k][1];
        assign bus.addr0  = aq[k][0];
        assign bus.addr1  = aq[k][1];
        assign bus.wdata0 = dq[k][0];
        assign bus.wdata1 = dq[k][1];
        assign bus.mem_q  = pipe[L-1];

        assign o_gnt0[k] = bus.gnt0;
        assign o_gnt1[k] = bus.gnt1;
        assign o_rv0[k]  = bus.rvalid0;
        assign o_rv1[k]  = bus.rvalid1;
        assign o_wren[k] = bus.mem_wren;
        assign o_addr[k] = bus.mem_address;
        assign o_data[k] = bus.mem_data;
        assign o_rd0[k]  = bus.rdata0;
        assign o_rd1[k]  = bus.rdata1;

        initial for (int a = 0; a < 4096; a++) mem[a] = init_word(k, a);

        always @(posedge clock) begin
            if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
            pipe[0] <= mem[bus.mem_address];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Transaction-level model: one access in flight, expected outputs scheduled by cycle number.
    logic [31:0] mdl_mem [3][4096];
    int          free_c [3];
    int          mlast  [3];
    int          g_cyc  [3];
    int          g_port [3];
    int          g_we   [3];
    int          r_cyc  [3];
    int          r_port [3];
    logic [31:0] r_data [3];
    int          a_from [3];
    int          a_to   [3];
    logic [11:0] a_val  [3];
    logic [31:0] d_val  [3];
    logic [31:0] e_rd   [3][2];

    int          glog   [3][16];
    int          gcnt   [3];
    int          glast  [3];
    int          rvlast [3];
    int          inflight [3];
    logic [11:0] hold_addr [3];
    int          hold_cnt [3];
    int          rv0cnt [3];
    int          wren_cnt [3];
    int          g1r0   [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        free_c[k] = 0;
        mlast[k]  = 1;
        g_cyc[k]  = -1;
        g_port[k] = 0;
        g_we[k]   = 0;
        r_cyc[k]  = -1;
        r_port[k] = 0;
        a_from[k] = 1;
        a_to[k]   = 0;
        e_rd[k][0] = '0;
        e_rd[k][1] = '0;
    endtask

    task automatic accept(input int k);
        int p;
        int t;
        int lat;
        if (cyc < free_c[k] || !(rq[k][0] || rq[k][1])) return;
        lat = (k == 2) ? 3 : 1;
        if (!rq[k][1])      p = 0;
        else if (!rq[k][0]) p = 1;
        else if (k == 1)    p = 0;
        else                p = 1 - mlast[k];
        t         = cyc + 1;
        mlast[k]  = p;
        g_cyc[k]  = t;
        g_port[k] = p;
        g_we[k]   = wq[k][p] ? 1 : 0;
        a_val[k]  = aq[k][p];
        d_val[k]  = dq[k][p];
        a_from[k] = t;
        if (wq[k][p]) begin
            mdl_mem[k][aq[k][p]] = dq[k][p];
            a_to[k]   = t;
            r_cyc[k]  = -1;
            free_c[k] = t + 1;
        end else begin
            a_to[k]   = t + lat;
            r_cyc[k]  = t + lat + 1;
            r_port[k] = p;
            r_data[k] = mdl_mem[k][aq[k][p]];
            free_c[k] = t + lat + 2;
        end
    endtask

    task automatic monitor(input int k);
        if (o_gnt0[k] || o_gnt1[k]) begin
            glast[k] = cyc;
            if (gcnt[k] < 16) glog[k][gcnt[k]] = o_gnt1[k] ? 1 : 0;
            gcnt[k]++;
            if (o_gnt1[k] && rq[k][0]) g1r0[k]++;
            inflight[k]  = 1;
            hold_addr[k] = o_addr[k];
            hold_cnt[k]  = 1;
        end else if (inflight[k] != 0 && !o_rv0[k] && !o_rv1[k] && o_addr[k] == hold_addr[k]) begin
            hold_cnt[k]++;
        end
        if (o_rv0[k] || o_rv1[k]) begin
            rvlast[k]   = cyc;
            inflight[k] = 0;
        end
        if (o_rv0[k]) rv0cnt[k]++;
        if (o_wren[k]) wren_cnt[k]++;
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                model_reset(k);
                chk("rst_gnt",    k, 32'({o_gnt1[k], o_gnt0[k]}), 32'd0);
                chk("rst_rvalid", k, 32'({o_rv1[k], o_rv0[k]}), 32'd0);
                chk("rst_wren",   k, 32'(o_wren[k]), 32'd0);
                chk("rst_addr",   k, 32'(o_addr[k]), 32'd0);
                chk("rst_data",   k, o_data[k], 32'd0);
                chk("rst_rdata0", k, o_rd0[k], 32'd0);
                chk("rst_rdata1", k, o_rd1[k], 32'd0);
            end else begin
                if (cyc == r_cyc[k]) e_rd[k][r_port[k]] = r_data[k];
                chk("gnt", k, 32'({o_gnt1[k], o_gnt0[k]}),
                    32'({cyc == g_cyc[k] && g_port[k] == 1, cyc == g_cyc[k] && g_port[k] == 0}));
                chk("rvalid", k, 32'({o_rv1[k], o_rv0[k]}),
                    32'({cyc == r_cyc[k] && r_port[k] == 1, cyc == r_cyc[k] && r_port[k] == 0}));
                chk("wren", k, 32'(o_wren[k]), 32'(cyc == g_cyc[k] && g_we[k] == 1));
                if (cyc >= a_from[k] && cyc <= a_to[k]) chk("addr", k, 32'(o_addr[k]), 32'(a_val[k]));
                if (cyc == g_cyc[k] && g_we[k] == 1) chk("wdata", k, o_data[k], d_val[k]);
                chk("rdata0", k, o_rd0[k], e_rd[k][0]);
                chk("rdata1", k, o_rd1[k], e_rd[k][1]);
                accept(k);
            end
            monitor(k);
        end
    end

    // Raise a request, hold it until the grant is seen, drop it at the edge ending the grant cycle.
    task automatic access(input int k, input int p, input logic w, input logic [11:0] a, input logic [31:0] d);
        int n;
        rq[k][p] = 1'b1;
        wq[k][p] = w;
        aq[k][p] = a;
        dq[k][p] = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(p == 1 ? o_gnt1[k] : o_gnt0[k]) && n < 300);
        chk("gnt_seen", k, 32'(p == 1 ? o_gnt1[k] : o_gnt0[k]), 32'd1);
        @(posedge clock);
        #1;
        rq[k][p] = 1'b0;
        aq[k][p] = ~a;
        dq[k][p] = ~d;
    endtask

    initial begin
        int s;
        int r0;
        int w0;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4096; a++) mdl_mem[k][a] = init_word(k, a);
            for (int p = 0; p < 2; p++) begin
                rq[k][p] = 1'b0;
                wq[k][p] = 1'b0;
                aq[k][p] = '0;
                dq[k][p] = '0;
            end
            model_reset(k);
            gcnt[k] = 0; glast[k] = 0; rvlast[k] = 0; inflight[k] = 0;
            hold_addr[k] = '0; hold_cnt[k] = 0; rv0cnt[k] = 0; wren_cnt[k] = 0; g1r0[k] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset arrives while a port-0 read is waiting on memory.
        access(0, 0, 1'b0, 12'h0AA, 32'h0);
        r0 = rv0cnt[0];
        reset = 1'b0;
        @(negedge clock);
        chk("t1_rdata0", 0, o_rd0[0], 32'h0);
        chk("t1_wren", 0, 32'(o_wren[0]), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("t1_no_rvalid0", 0, 32'(rv0cnt[0] - r0), 32'd0);

        // Both ports hold read requests under round-robin.
        s = gcnt[0];
        fork
            begin
                access(0, 0, 1'b0, 12'h100, 32'h0);
                access(0, 0, 1'b0, 12'h101, 32'h0);
            end
            begin
                access(0, 1, 1'b0, 12'h200, 32'h0);
                access(0, 1, 1'b0, 12'h201, 32'h0);
            end
        join
        repeat (6) @(posedge clock);
        #1;
        chk("t3_order0", 0, 32'(glog[0][s]),   32'd0);
        chk("t3_order1", 0, 32'(glog[0][s+1]), 32'd1);
        chk("t3_order2", 0, 32'(glog[0][s+2]), 32'd0);
        chk("t3_order3", 0, 32'(glog[0][s+3]), 32'd1);
        chk("t3_rdata0", 0, o_rd0[0], 32'h5000_0101);
        chk("t3_rdata1", 0, o_rd1[0], 32'h5000_0201);

        // Write then read back through port 0.
        w0 = wren_cnt[0];
        access(0, 0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        access(0, 0, 1'b0, 12'h010, 32'h0);
        repeat (4) @(posedge clock);
        #1;
        chk("t2_wren_cycles", 0, 32'(wren_cnt[0] - w0), 32'd1);
        chk("t2_latency", 0, 32'(rvlast[0] - glast[0]), 32'd2);
        chk("t2_rdata0", 0, o_rd0[0], 32'hDEAD_BEEF);

        // Top-of-space write from port 1, read from port 0.
        access(0, 1, 1'b1, 12'hFFF, 32'h1234_5678);
        access(0, 0, 1'b0, 12'hFFF, 32'h0);
        repeat (4) @(posedge clock);
        #1;
        chk("t5_rdata0", 0, o_rd0[0], 32'h1234_5678);
        chk("t5_rdata1", 0, o_rd1[0], 32'h5000_0201);

        // Fixed priority: port 0 keeps re-requesting, port 1 waits it out.
        s = gcnt[1];
        fork
            begin
                access(1, 0, 1'b0, 12'h300, 32'h0);
                access(1, 0, 1'b0, 12'h301, 32'h0);
                access(1, 0, 1'b0, 12'h302, 32'h0);
            end
            begin
                access(1, 1, 1'b0, 12'h3F0, 32'h0);
            end
        join
        repeat (5) @(posedge clock);
        #1;
        chk("t4_gnt1_while_req0", 1, 32'(g1r0[1]), 32'd0);
        chk("t4_order0", 1, 32'(glog[1][s]),   32'd0);
        chk("t4_order1", 1, 32'(glog[1][s+1]), 32'd0);
        chk("t4_order2", 1, 32'(glog[1][s+2]), 32'd0);
        chk("t4_order3", 1, 32'(glog[1][s+3]), 32'd1);
        chk("t4_rdata1", 1, o_rd1[1], 32'h5100_03F0);

        // Three-cycle read latency.
        access(2, 0, 1'b1, 12'h000, 32'hCAFE_F00D);
        access(2, 0, 1'b0, 12'h000, 32'h0);
        repeat (6) @(posedge clock);
        #1;
        chk("t6_rdata0", 2, o_rd0[2], 32'hCAFE_F00D);
        access(2, 1, 1'b0, 12'h345, 32'h0);
        repeat (6) @(posedge clock);
        #1;
        chk("t6_latency", 2, 32'(rvlast[2] - glast[2]), 32'd4);
        chk("t6_addr_hold", 2, 32'(hold_cnt[2]), 32'd4);
        chk("t6_rdata1", 2, o_rd1[2], 32'h5200_0345);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
